// File: rtl/dct_accum_addsub.sv
// dct_accum_addsub -- pipelined signed add/subtract accumulator for the
// 8-point 2D DCT datapath. Sums TERMS tagged products per coefficient and
// emits one W-bit result per group through a valid/ready output register.
//
// Optional build macro: DCT_ACCUM_SAT_EN
//   defined   -> out_data saturates to the W-bit signed range on overflow
//   undefined -> out_data is the low W bits of the sum (two's-complement wrap)
// out_ovf flags an out-of-range group sum in both builds.
module dct_accum_addsub #(
    parameter int W     = 16,
    parameter int TERMS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         busy
);

    // Guard bits sized so TERMS full-scale terms, including the negation of
    // the most negative operand, can never wrap the accumulator.
    localparam int AW = W + $clog2(TERMS) + 1;
    localparam int CW = $clog2(TERMS);

    localparam logic [CW-1:0] LAST_CNT = CW'(TERMS - 1);

    // Representable W-bit signed range, expressed at accumulator width.
    localparam logic signed [AW-1:0] SUM_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SUM_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

`ifdef DCT_ACCUM_SAT_EN
    localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    // Group phase is fully determined by the term counter.
    typedef enum logic {
        PH_IDLE  = 1'b0,
        PH_ACCUM = 1'b1
    } phase_e;

    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 out_ovf_q, out_ovf_d;

    logic signed [AW-1:0] term_sext;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] sum;
    logic                 sum_hi;
    logic                 sum_lo;
    logic [W-1:0]         res_data;
    logic                 fire;
    logic                 last_beat;
    logic                 consume;
    phase_e               phase;

    assign phase    = (cnt_q == '0) ? PH_IDLE : PH_ACCUM;
    assign busy     = (phase == PH_ACCUM);
    assign in_ready = (~out_valid_q | out_ready) & ~clr;
    assign fire     = in_valid & in_ready;
    assign consume  = out_valid_q & out_ready;
    assign last_beat = (cnt_q == LAST_CNT);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Term datapath: sign-extend, optionally negate, add to the running sum,
    // then classify the full-precision result against the W-bit range.
    always_comb begin
        term_sext = {{(AW-W){in_data[W-1]}}, in_data};
        term      = in_sub ? (~term_sext + AW'(1)) : term_sext;
        // acc_q is zero in IDLE, so this also yields the first term of a group.
        sum       = acc_q + term;
        sum_hi    = (sum > SUM_MAX);
        sum_lo    = (sum < SUM_MIN);
`ifdef DCT_ACCUM_SAT_EN
        res_data  = sum_hi ? OUT_MAX : (sum_lo ? OUT_MIN : sum[W-1:0]);
`else
        res_data  = sum[W-1:0];
`endif
    end

    // Next-state for accumulator, counter and output register.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (fire) begin
            if (last_beat) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (consume) begin
            out_valid_d = 1'b0;
        end
        // A completing group may load in the same cycle the old result leaves.
        if (fire && last_beat) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_ovf_d   = sum_hi | sum_lo;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_dct_accum_addsub.sv
// Self-checking bench for dct_accum_addsub (W=16, TERMS=8). A beat-level
// model collects accepted products, sums each complete group with plain
// integer arithmetic and tracks the pending result; every cycle the DUT
// outputs are compared with it. Literal checks pin the model on known sums.
module tb_dct_accum_addsub;

    localparam int W     = 16;
    localparam int TERMS = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    dct_accum_addsub #(.W(W), .TERMS(TERMS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    typedef struct {
        logic [W-1:0] d;
        bit           sub;
    } beat_t;

    beat_t        m_beats[$];
    bit           m_ov;
    logic [W-1:0] m_data;
    bit           m_ovf;
    bit           m_fired;

    task automatic model_reset();
        m_beats.delete();
        m_ov    = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_fired = 1'b0;
    endtask

    // Sum the collected group at full precision and form the expected result.
    task automatic model_finish_group();
        longint      s;
        logic [63:0] s_bits;
        s = 0;
        foreach (m_beats[i]) begin
            longint v;
            v = longint'($signed(m_beats[i].d));
            s = m_beats[i].sub ? s - v : s + v;
        end
        m_ovf  = (s > 32767) || (s < -32768);
        s_bits = s;
`ifdef DCT_ACCUM_SAT_EN
        if (s > 32767)       m_data = 16'h7FFF;
        else if (s < -32768) m_data = 16'h8000;
        else                 m_data = s_bits[15:0];
`else
        m_data = s_bits[15:0];
`endif
        m_ov = 1'b1;
        m_beats.delete();
    endtask

    // Advance the model across one clock edge using the pre-edge inputs.
    task automatic model_edge(input bit ready);
        bit    fire;
        bit    consume;
        beat_t b;
        fire    = in_valid && ready;
        consume = m_ov && out_ready;
        m_fired = fire;
        if (clr) m_beats.delete();
        if (consume) m_ov = 1'b0;
        if (fire) begin
            b.d   = in_data;
            b.sub = in_sub;
            m_beats.push_back(b);
            if (m_beats.size() == TERMS) model_finish_group();
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check in_ready before the edge, update the model at the
    // edge, then compare registered outputs shortly after it.
    task automatic step();
        bit exp_ready;
        #1;
        exp_ready = (!m_ov || out_ready) && !clr;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        @(posedge clk);
        model_edge(exp_ready);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("out_data",  {16'd0, out_data},  {16'd0, m_data});
        check("out_ovf",   {31'd0, out_ovf},   {31'd0, m_ovf});
        check("busy",      {31'd0, busy},      {31'd0, (m_beats.size() != 0)});
    endtask

    task automatic send(input logic [W-1:0] d, input bit s);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        guard    = 0;
        do begin
            step();
            guard++;
        end while (!m_fired && guard < 50);
        if (!m_fired) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: beat 0x%0h not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"},  {16'd0, out_data},  32'd0);
        check({tag, "_out_ovf"},   {31'd0, out_ovf},   32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ovf_exp;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        model_reset();
`ifdef DCT_ACCUM_SAT_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'h0000;
`endif

        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Group 1: 1..8 added back-to-back -> 36, valid for one cycle.
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        check("g1_valid", {31'd0, out_valid}, 32'd1);
        check("g1_data",  {16'd0, out_data},  32'd36);
        check("g1_model", {16'd0, m_data},    32'd36);
        idle(1);
        check("g1_valid_drop", {31'd0, out_valid}, 32'd0);

        // Mixed signs, subtract of a negative, with a gap mid-group -> 72.
        send(16'd100, 1'b0);
        send(16'd30, 1'b1);
        idle(2);
        send(-16'sd5, 1'b0);
        send(-16'sd7, 1'b1);
        for (int i = 0; i < 4; i++) send(16'd0, 1'b0);
        check("mix_data",  {16'd0, out_data}, 32'd72);
        check("mix_model", {16'd0, m_data},   32'd72);
        check("mix_ovf",   {31'd0, out_ovf},  32'd0);

        // Positive overflow: 8 x 0x4000 = 131072.
        for (int i = 0; i < 8; i++) send(16'h4000, 1'b0);
        check("ovfp_flag", {31'd0, out_ovf},  32'd1);
        check("ovfp_data", {16'd0, out_data}, {16'd0, ovf_exp});
        // Subtracting the most negative value 8 times: +262144.
        for (int i = 0; i < 8; i++) send(16'h8000, 1'b1);
        check("ovfn_flag", {31'd0, out_ovf},  32'd1);
        check("ovfn_data", {16'd0, out_data}, {16'd0, ovf_exp});
        idle(1);

        // Back-pressure: hold result 36, beats of group 2 must stall.
        for (int i = 1; i <= 7; i++) send(16'(i), 1'b0);
        out_ready = 1'b0;
        send(16'd8, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd3;
        in_sub   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold",  {16'd0, out_data}, 32'd36);
        end
        check("stall_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'd3, 1'b0);
        check("resume_data", {16'd0, out_data}, 32'd24);
        idle(1);

        // Abort: four beats of 5, clr with in_valid high, then eight of 1 -> 8.
        for (int i = 0; i < 4; i++) send(16'd5, 1'b0);
        check("pre_clr_busy", {31'd0, busy}, 32'd1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd5;
        #1;
        check("clr_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("clr_busy", {31'd0, busy}, 32'd0);
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd1, 1'b0);
        check("post_clr_data", {16'd0, out_data}, 32'd8);
        idle(1);

        // Async reset mid-group: partial sum discarded; next 8 x 2 -> 16.
        for (int i = 0; i < 5; i++) send(16'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(16'd2, 1'b0);
        check("post_rst_data", {16'd0, out_data}, 32'd16);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dct_accum_addsub.md
Name: dct_accum_addsub

Overview:
- Pipelined, parametrised signed add/subtract accumulator for the 8-point 2D DCT datapath.
- Sits after the coefficient multipliers. Consumes a stream of W-bit two's-complement products, each tagged add or subtract.
- Sums TERMS products per coefficient and emits one W-bit result per group.
- Valid/ready handshakes on both sides, overflow flag, synchronous abort.

Parameters:
- W, 16, operand and result width (two's complement, MSB is sign); legal 4..32.
- TERMS, 8, products summed per result; legal 2..256.
- AW (localparam), W+$clog2(TERMS)+1, internal accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort of the partial group; the output register is unaffected.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  W  signed product.
- in_sub  in  1  0: acc += in_data; 1: acc -= in_data.
- out_valid  out  1  result held valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  W  signed result.
- out_ovf  out  1  full-precision group sum outside the W-bit signed range.
- busy  out  1  partial group in progress (cnt != 0).

Behaviour:
- Reset (async assert, sync deassert handled upstream): acc=0, cnt=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
- Term datapath: sext(in_data) to AW bits. Subtract is ~sext + 1 (true two's-complement negation). Negating -2^(W-1) is exact because AW > W.
- States:
  - IDLE (cnt==0): a fire with TERMS>1 gives acc=±in, cnt=1, go to ACCUM.
  - ACCUM (0<cnt<TERMS): each fire gives acc=acc±in, cnt+1.
  - On the fire with cnt==TERMS-1: sum=acc±in goes to the output register; acc=0, cnt=0, back to IDLE.
- Latency: out_valid rises on the cycle after the TERMS-th accepted beat. Throughput is one beat per cycle with no bubbles between groups.
- in_ready = (~out_valid | out_ready) & ~clr. Combinational, no dependence on in_valid.
  - Input therefore stalls while an unconsumed result is held, even mid-group.
  - A group may complete in the same cycle the previous result is consumed; out_valid stays 1 and out_data updates.
- Output register:
  - out_valid clears on consume unless a new result loads the same cycle.
  - out_data, out_ovf and out_valid hold stable while out_valid & ~out_ready.
- out_ovf = 1 when sum > 2^(W-1)-1 or sum < -2^(W-1), evaluated on the full AW-bit sum.
- clr:
  - Forces acc=0, cnt=0 next cycle. in_ready is 0 during clr, so no beat is taken.
  - clr while out_valid: the result is kept and still handshakes normally.
  - clr in IDLE: no effect.
- in_valid low: no state change. Gaps between beats of a group are allowed.
- Reset mid-group: partial sum discarded. Reset with out_valid=1: result lost.
- AW guard bits guarantee the internal accumulator never wraps for any TERMS within the legal range.

Optional Feature:
- Macro DCT_ACCUM_SAT_EN.
- Defined: out_data saturates to 2^(W-1)-1 when sum is too large and to -2^(W-1) when too small; out_ovf still flags the event.
- Undefined: out_data = sum[W-1:0] (two's-complement wrap); out_ovf still flags the event.
- All other timing is identical in both builds.

Test Plan:
- W=16, TERMS=8, out_ready=1. Beats 1..8 all add, back-to-back.
  -> out_data=36 (0x0024), out_ovf=0, out_valid for one cycle, one cycle after the 8th beat.
- Beats +100, -(30), +(-5), -(-7), then +0 x4 (in_sub=1 where a minus is shown).
  -> out_data=72. Covers negative operands and subtract of a negative.
- Eight beats of 0x4000 add.
  -> sum=131072, out_ovf=1. Out_data=0x0000 without DCT_ACCUM_SAT_EN; 0x7FFF with it. Repeat with 0x8000 subtract x8: out_ovf=1, out_data=0x0000 (wrap) / 0x7FFF (sat).
- out_ready=0 after group 1; drive 3 beats of group 2.
  -> in_ready=0, no beat accepted, out_data holds 36. Raise out_ready: group 2 resumes and completes with correct sum.
- Four beats of 5, then clr=1 for 1 cycle with in_valid=1, then eight beats of 1.
  -> in_ready=0 during clr; busy falls; next result=8.
- rst_n low for 1 cycle after 5 beats.
  -> all outputs 0 immediately (async). The next 8 beats of 2 give 16.
